// File: rtl/layer3_ctrl.sv
// layer3_ctrl -- sequencer around one fully-combinational network layer.
//
// It collects 10 activation words into R_bus, waits LAT cycles for the layer
// to settle, snapshots the 15 results from N_bus, then streams them out
// with a valid/ready handshake (N1 first).
//
// Parameters
//   LAT  cycles from a stable R_bus to valid N_bus results (1..15)
//   W    activation word width
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   / in_ready / in_data    input word stream (ready only in LOAD)
//   R_bus      10 packed layer inputs, word k at [k*W +: W]
//   N_bus      15 packed layer results, word j-1 holds Nj
//   out_valid  / out_ready / out_data  result word stream
//   out_idx    index of out_data (0 = N1), out_last high with index 14
//   busy       high whenever a frame is partly loaded, settling or draining
//   frame_cnt  completed-frame counter (only with LAYER3_CTRL_PERF_EN)
//
// Optional feature: define LAYER3_CTRL_PERF_EN to add the frame_cnt port.

module layer3_ctrl #(
    parameter int LAT = 4,
    parameter int W   = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic [10*W-1:0] R_bus,
    input  logic [15*W-1:0] N_bus,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [3:0]      out_idx,
    output logic            out_last,
`ifdef LAYER3_CTRL_PERF_EN
    output logic [15:0]     frame_cnt,
`endif
    output logic            busy
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t       state;
    logic [3:0]   ld_cnt;
    logic [3:0]   wait_cnt;
    logic [3:0]   rd_idx;
    logic [3:0]   rd_next;
    logic         drain_done;
    logic [W-1:0] res_buf [15];

    assign rd_next    = rd_idx + 4'd1;
    assign drain_done = (state == DRAIN) && out_ready && (rd_idx == 4'd14);

    // Both are pure decodes of registered state, so they are glitch-free.
    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD) || (ld_cnt != 4'd0);

    // NOTE: every register here, including the result buffer, is assigned
    // with <= so all of them update together from the same pre-edge values;
    // the buffer is reset too because a reset must leave no stale results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            ld_cnt    <= '0;
            wait_cnt  <= '0;
            rd_idx    <= '0;
            R_bus     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < 15; i++) res_buf[i] <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        R_bus[ld_cnt*W +: W] <= in_data;
                        if (ld_cnt == 4'd9) begin
                            state    <= WAIT;
                            ld_cnt   <= '0;
                            wait_cnt <= 4'(LAT - 1);
                        end else begin
                            ld_cnt <= ld_cnt + 4'd1;
                        end
                    end
                end

                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        // Snapshot the settled layer outputs; later N_bus
                        // activity cannot reach the emitted words.
                        for (int j = 0; j < 15; j++) res_buf[j] <= N_bus[j*W +: W];
                        state     <= DRAIN;
                        rd_idx    <= '0;
                        out_valid <= 1'b1;
                        out_data  <= N_bus[W-1:0];
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                DRAIN: begin
                    // Without a transfer every output register simply holds.
                    if (out_ready) begin
                        if (rd_idx == 4'd14) begin
                            state     <= LOAD;
                            rd_idx    <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_idx   <= rd_next;
                            out_data <= res_buf[rd_next];
                            out_idx  <= rd_next;
                            out_last <= (rd_next == 4'd14);
                        end
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

`ifdef LAYER3_CTRL_PERF_EN
    // Counts completed drains; 16-bit addition wraps 65535 -> 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_cnt <= '0;
        else if (drain_done) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule
